fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL provide parameter XLEN, default 32, address/instruction width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port imem_req, output, 1, instruction-memory request valid.
REQ-006 SHALL have port imem_addr, output, XLEN, request address, word-aligned.
REQ-007 SHALL have port imem_gnt, input, 1, request accepted this cycle.
REQ-008 SHALL have port imem_rvalid, input, 1, response data valid.
REQ-009 SHALL have port imem_rdata, input, XLEN, fetched instruction.
REQ-010 SHALL have port stall_i, input, 1, decode cannot accept; hold IF/ID output.
REQ-011 SHALL have port redirect_i, input, 1, branch/jump taken in EX; flush and refetch.
REQ-012 SHALL have port redirect_pc_i, input, XLEN, redirect target.
REQ-013 SHALL have ports if_id_valid_o (1), if_id_pc_o (XLEN), if_id_instr_o (XLEN), outputs, IF/ID register contents.

Function
REQ-014 SHALL run FSM states REQ (imem_req=1), WAIT (request granted, awaiting rvalid), HOLD (response buffered, decode stalled).
REQ-015 SHALL allow at most one outstanding memory request.
REQ-016 REQ: on imem_gnt go WAIT and latch issued address; imem_addr and imem_req stable until granted.
REQ-017 WAIT: on imem_rvalid with (if_id_valid_o=0 or stall_i=0) load IF/ID {1, issued addr, imem_rdata}, pc <= pc+4, go REQ.
REQ-018 WAIT: on imem_rvalid with if_id_valid_o=1 and stall_i=1, capture into one-entry hold buffer, go HOLD.
REQ-019 HOLD: imem_req=0; when stall_i=0, move hold buffer into IF/ID, go REQ.
REQ-020 stall_i=1 with valid IF/ID SHALL keep all three IF/ID outputs unchanged.
REQ-021 stall_i=0 with no new instruction SHALL clear if_id_valid_o next cycle.
REQ-022 redirect_i SHALL have priority over stall_i and any response: next cycle if_id_valid_o=0, hold buffer invalidated, pc <= {redirect_pc_i[XLEN-1:2],2'b00}.
REQ-023 Redirect in REQ or HOLD SHALL go to REQ and issue the target the following cycle.
REQ-024 Redirect in WAIT SHALL set a drop flag; the pending response is discarded on arrival, then go REQ with the target.
REQ-025 Redirect in the same cycle as imem_rvalid SHALL discard that response.
REQ-026 PC increment SHALL wrap modulo 2^XLEN (32'hFFFF_FFFC + 4 = 0).
REQ-027 Latency: no stall, grant in issue cycle, rvalid next cycle -> IF/ID valid 2 cycles after issue; sustained throughput one instruction per 2 cycles.

Reset
REQ-028 rst_n=0 at a clock edge SHALL set pc=RESET_PC, state=REQ, drop flag=0, hold buffer invalid, if_id_valid_o=0, if_id_pc_o=0, if_id_instr_o=32'h0000_0013 (NOP).
REQ-029 imem_req SHALL be 0 while rst_n=0 and 1 on the first cycle after release.
REQ-030 Reset mid-WAIT SHALL discard the outstanding response; an imem_rvalid in the first post-reset cycle SHALL be ignored.

Structure
REQ-031 Shared package pipe_pkg SHALL hold XLEN, RESET_PC default, NOP encoding and the fetch FSM state enum.
REQ-032 The IF/ID register with load/flush/hold controls SHALL be sub-module if_id_reg.

Verification
REQ-033 Reset release, gnt immediate, rvalid next cycle with rdata=32'h0010_0093 -> IF/ID valid, pc=0, instr=32'h0010_0093; next imem_addr=4.
REQ-034 stall_i high 3 cycles with IF/ID valid and a response arriving -> IF/ID frozen, imem_req=0 in HOLD; after release buffered instruction appears, pc+4.
REQ-035 redirect_i with redirect_pc_i=32'h0000_0103 while WAIT -> response dropped, if_id_valid_o=0, next imem_addr=32'h0000_0100.
REQ-036 redirect_i and stall_i high together -> flush wins, if_id_valid_o=0 next cycle.
REQ-037 pc=32'hFFFF_FFFC fetch completes -> next imem_addr=32'h0000_0000.
REQ-038 rst_n low during WAIT, rvalid arrives in the first post-reset cycle -> ignored; imem_addr=RESET_PC, if_id_valid_o=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath width, reset vector, NOP encoding and fetch FSM states.
package pipe_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_HOLD
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold; an idle, unstalled cycle drops valid.
module if_id_reg
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN = pipe_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            load_i,
  input  logic            stall_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= XLEN'(NOP_INSTR);
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end else if (!stall_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, a one-entry hold buffer for stalled
// decode, and redirect handling that drops any in-flight response.
module fetch_stage
  import pipe_pkg::*;
#(
  parameter int unsigned     XLEN     = pipe_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            if_id_valid_o,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [XLEN-1:0] if_id_instr_o
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] issued_q;
  logic            drop_q;
  logic            hold_valid_q;
  logic [XLEN-1:0] hold_pc_q;
  logic [XLEN-1:0] hold_instr_q;

  logic            wait_accept_d;
  logic            hold_release_d;
  logic            load_d;
  logic [XLEN-1:0] load_pc_d;
  logic [XLEN-1:0] load_instr_d;

  assign imem_req  = rst_n && (state_q == FETCH_REQ);
  assign imem_addr = pc_q;

  assign wait_accept_d  = (state_q == FETCH_WAIT) && imem_rvalid && !drop_q && !redirect_i
                          && (!if_id_valid_o || !stall_i);
  assign hold_release_d = (state_q == FETCH_HOLD) && hold_valid_q && !stall_i && !redirect_i;
  assign load_d         = wait_accept_d || hold_release_d;
  assign load_pc_d      = hold_release_d ? hold_pc_q    : issued_q;
  assign load_instr_d   = hold_release_d ? hold_instr_q : imem_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FETCH_REQ;
      pc_q         <= RESET_PC & ALIGN_MASK;
      issued_q     <= '0;
      drop_q       <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= XLEN'(NOP_INSTR);
    end else if (redirect_i) begin
      pc_q         <= redirect_pc_i & ALIGN_MASK;
      hold_valid_q <= 1'b0;
      case (state_q)
        // A grant coinciding with the redirect still owes a response; mark it for discard.
        FETCH_REQ: begin
          if (imem_gnt) begin
            state_q  <= FETCH_WAIT;
            issued_q <= pc_q;
            drop_q   <= 1'b1;
          end
        end
        FETCH_WAIT: begin
          if (imem_rvalid) begin
            state_q <= FETCH_REQ;
            drop_q  <= 1'b0;
          end else begin
            drop_q  <= 1'b1;
          end
        end
        default: state_q <= FETCH_REQ;
      endcase
    end else begin
      case (state_q)
        FETCH_REQ: begin
          if (imem_gnt) begin
            state_q  <= FETCH_WAIT;
            issued_q <= pc_q;
          end
        end
        FETCH_WAIT: begin
          if (imem_rvalid) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= FETCH_REQ;
            end else begin
              pc_q <= issued_q + XLEN'(4);
              if (if_id_valid_o && stall_i) begin
                hold_valid_q <= 1'b1;
                hold_pc_q    <= issued_q;
                hold_instr_q <= imem_rdata;
                state_q      <= FETCH_HOLD;
              end else begin
                state_q <= FETCH_REQ;
              end
            end
          end
        end
        FETCH_HOLD: begin
          if (!stall_i) begin
            hold_valid_q <= 1'b0;
            state_q      <= FETCH_REQ;
          end
        end
        default: state_q <= FETCH_REQ;
      endcase
    end
  end

  if_id_reg #(
    .XLEN(XLEN)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_i),
    .load_i  (load_d),
    .stall_i (stall_i),
    .pc_i    (load_pc_d),
    .instr_i (load_instr_d),
    .valid_o (if_id_valid_o),
    .pc_o    (if_id_pc_o),
    .instr_o (if_id_instr_o)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes expected IF/ID entries, a negedge monitor pops them.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        if_id_valid_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_instr_o;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  logic        held = 1'b0;

  always #5 clk = ~clk;

  fetch_stage #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .if_id_valid_o (if_id_valid_o),
    .if_id_pc_o    (if_id_pc_o),
    .if_id_instr_o (if_id_instr_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Monitor: a fresh IF/ID entry is one that is valid and was not frozen by stall last cycle.
  always @(negedge clk) begin
    if (rst_n && if_id_valid_o && !held) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL ifid_unexpected actual=pc %h instr %h expected=no entry", if_id_pc_o, if_id_instr_o);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({if_id_pc_o, if_id_instr_o} !== e) begin
          failures++;
          $display("FAIL ifid_entry actual=pc %h instr %h expected=pc %h instr %h",
                   if_id_pc_o, if_id_instr_o, e[63:32], e[31:0]);
        end
      end
    end
    held = if_id_valid_o && stall_i;
  end

  initial begin
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    tick(); tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, if_id_valid_o}, 32'd0);
    chk("rst_pc", if_id_pc_o, 32'd0);
    chk("rst_instr", if_id_instr_o, NOP);

    // Basic fetch after reset release
    rst_n = 1'b1; imem_gnt = 1'b1; settle();
    chk("rel_req", {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'd0);
    tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0010_0093;
    exp_q.push_back({32'h0, 32'h0010_0093}); settle();
    chk("wait_req", {31'd0, imem_req}, 32'd0);
    tick(); imem_rvalid = 1'b0; stall_i = 1'b1; imem_gnt = 1'b1; settle();
    chk("first_valid", {31'd0, if_id_valid_o}, 32'd1);
    chk("next_addr", imem_addr, 32'd4);

    // Stall with a response arriving -> hold buffer
    tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
    exp_q.push_back({32'h4, 32'h00A0_0113}); settle();
    chk("stall_frozen_pc", if_id_pc_o, 32'd0);
    tick(); imem_rvalid = 1'b0; settle();
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    chk("hold_valid", {31'd0, if_id_valid_o}, 32'd1);
    chk("hold_instr", if_id_instr_o, 32'h0010_0093);
    tick(); stall_i = 1'b0; settle();
    chk("hold_req2", {31'd0, imem_req}, 32'd0);
    chk("hold_pc2", if_id_pc_o, 32'd0);
    tick(); settle();
    chk("release_pc", if_id_pc_o, 32'd4);
    chk("release_instr", if_id_instr_o, 32'h00A0_0113);
    chk("release_addr", imem_addr, 32'd8);

    // Redirect while WAIT -> response dropped
    imem_gnt = 1'b1;
    tick(); imem_gnt = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103; settle();
    chk("redir_wait_req", {31'd0, imem_req}, 32'd0);
    tick(); redirect_i = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0001; settle();
    chk("redir_flush_valid", {31'd0, if_id_valid_o}, 32'd0);
    chk("drop_still_wait", {31'd0, imem_req}, 32'd0);
    tick(); imem_rvalid = 1'b0; settle();
    chk("redir_addr", imem_addr, 32'h0000_0100);
    chk("redir_req", {31'd0, imem_req}, 32'd1);
    chk("drop_valid", {31'd0, if_id_valid_o}, 32'd0);

    // Redirect and stall together -> flush wins
    imem_gnt = 1'b1;
    tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0B00_0B13;
    exp_q.push_back({32'h100, 32'h0B00_0B13});
    tick(); imem_rvalid = 1'b0; stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200; settle();
    chk("pre_flush_valid", {31'd0, if_id_valid_o}, 32'd1);
    tick(); stall_i = 1'b0; redirect_i = 1'b0; settle();
    chk("flush_wins_valid", {31'd0, if_id_valid_o}, 32'd0);
    chk("flush_addr", imem_addr, 32'h0000_0200);

    // PC wrap, with an unaligned target
    tick(); redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
    tick(); redirect_i = 1'b0; imem_gnt = 1'b1; settle();
    chk("wrap_issue_addr", imem_addr, 32'hFFFF_FFFC);
    tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0C00_0C13;
    exp_q.push_back({32'hFFFF_FFFC, 32'h0C00_0C13});
    tick(); imem_rvalid = 1'b0; settle();
    chk("wrap_next_addr", imem_addr, 32'h0000_0000);

    // Redirect in the same cycle as rvalid
    imem_gnt = 1'b1;
    tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0002;
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0040;
    tick(); imem_rvalid = 1'b0; redirect_i = 1'b0; settle();
    chk("same_cycle_addr", imem_addr, 32'h0000_0040);
    chk("same_cycle_req", {31'd0, imem_req}, 32'd1);
    chk("same_cycle_valid", {31'd0, if_id_valid_o}, 32'd0);

    // Reset during WAIT, stale rvalid right after release
    imem_gnt = 1'b1;
    tick(); imem_gnt = 1'b0; rst_n = 1'b0; settle();
    chk("in_reset_req", {31'd0, imem_req}, 32'd0);
    tick(); rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0003; settle();
    chk("post_rst_addr", imem_addr, 32'd0);
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    tick(); imem_rvalid = 1'b0; settle();
    chk("stale_ignored_valid", {31'd0, if_id_valid_o}, 32'd0);
    chk("stale_ignored_req", {31'd0, imem_req}, 32'd1);
    chk("stale_ignored_addr", imem_addr, 32'd0);

    imem_gnt = 1'b1;
    tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0D00_0D13;
    exp_q.push_back({32'h0, 32'h0D00_0D13});
    tick(); imem_rvalid = 1'b0; settle();
    chk("final_addr", imem_addr, 32'd4);

    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
